uart_rx: RTL and testbench

- UART receiver that sits directly downstream of the UART transmitter and consumes its serial line.
- Frame format is 8N1 by default: 1 start bit (low), 8 data bits LSB first, 1 stop bit (high).
- Samples each bit at mid-bit and presents each received byte with a one-cycle valid pulse.
- Flags framing errors and rejects glitch (false) start bits.

---
 rtl/uart_rx.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with two-flop input sync, mid-bit sampling, false-start rejection
// and framing-error/break handling. Define UART_RX_PARITY_EN to add an even-parity bit (o_parity_err).
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_serial,
  output logic       o_rx_dv,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_act,
`ifdef UART_RX_PARITY_EN
  output logic       o_parity_err,
`endif
  output logic       o_frame_err
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd5,
`endif
    BREAK = 3'd4
  } state_t;

  logic        rx_meta, rx_s;
  state_t      state_q, state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_ind_q, bit_ind_d;
  logic [7:0]  shift_q, shift_d, byte_d;
  logic        dv_d, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic        par_q, par_d, perr_d;
`endif

  // Idle level is high, so both flops reset to 1 to avoid a phantom start bit.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx_serial;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_ind_q   <= '0;
      o_rx_byte   <= '0;
      o_rx_dv     <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_ind_q   <= bit_ind_d;
      o_rx_byte   <= byte_d;
      o_rx_dv     <= dv_d;
      o_frame_err <= ferr_d;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= perr_d;
`endif
    end
  end

  // NOTE: the shift register is pure datapath, fully rewritten before use, so it carries no reset.
  always_ff @(posedge i_clk) begin
    shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
    par_q   <= par_d;
`endif
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_ind_d = bit_ind_q;
    shift_d   = shift_q;
    byte_d    = o_rx_byte;
    dv_d      = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        bit_ind_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (clk_cnt_q < HALF) begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end else begin
          clk_cnt_d = '0;
          state_d   = rx_s ? IDLE : DATA;  // high at mid start bit is a glitch
        end
      end
      DATA: begin
        if (clk_cnt_q < LAST) begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end else begin
          clk_cnt_d          = '0;
          shift_d[bit_ind_q] = rx_s;
          if (bit_ind_q < 3'd7) begin
            bit_ind_d = bit_ind_q + 3'd1;
          end else begin
            bit_ind_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_cnt_q < LAST) begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end else begin
          clk_cnt_d = '0;
          par_d     = rx_s;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (clk_cnt_q < LAST) begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end else begin
          clk_cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (^{shift_q, par_q}) begin
              perr_d = 1'b1;
            end else begin
              byte_d = shift_q;
              dv_d   = 1'b1;
            end
`else
            byte_d  = shift_q;
            dv_d    = 1'b1;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        clk_cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_rx_act = 1'b0;
    case (state_q)
      START, DATA, STOP: o_rx_act = 1'b1;
`ifdef UART_RX_PARITY_EN
      PARITY:            o_rx_act = 1'b1;
`endif
      default:           o_rx_act = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (CLKS_PER_BIT=4): directed table, corner sequences and
// randomized frames checked against an event-level model of expected pulses and timing.
module tb_uart_rx;

  localparam int C   = 4;
  localparam int H   = (C - 1) / 2;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 3 + H + 10 * C;
`else
  localparam int LAT = 3 + H + 9 * C;
`endif
  localparam int K_DV   = 0;
  localparam int K_FERR = 1;
  localparam int K_PERR = 2;

  typedef struct {
    int         t;
    int         kind;
    logic [7:0] b;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       stop_b;
    int         low_after;
    int         gap;
    int         exp_kind;
    logic [7:0] exp_byte;
  } vec_t;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_rx_serial;
  logic       o_rx_dv;
  logic [7:0] o_rx_byte;
  logic       o_rx_act;
  logic       o_frame_err;
`ifdef UART_RX_PARITY_EN
  logic       o_parity_err;
`endif

  int   cyc = 0;
  int   act_cnt = 0;
  int   checks = 0;
  int   failures = 0;
  ev_t  exp_q[$];
  ev_t  obs_q[$];
  logic [7:0] last_good;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_rx_serial (i_rx_serial),
    .o_rx_dv     (o_rx_dv),
    .o_rx_byte   (o_rx_byte),
    .o_rx_act    (o_rx_act),
`ifdef UART_RX_PARITY_EN
    .o_parity_err(o_parity_err),
`endif
    .o_frame_err (o_frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_rx_dv)     obs_q.push_back('{t: cyc, kind: K_DV, b: o_rx_byte});
    if (o_frame_err) obs_q.push_back('{t: cyc, kind: K_FERR, b: o_rx_byte});
`ifdef UART_RX_PARITY_EN
    if (o_parity_err) obs_q.push_back('{t: cyc, kind: K_PERR, b: o_rx_byte});
`endif
    if (o_rx_act) act_cnt <= act_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      i_rx_serial = b;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_b, input logic stop_b,
                            input int low_after, input int gap, output int t0);
    @(negedge clk);
    i_rx_serial = 1'b0;
    t0 = cyc;
    drive(1'b0, C - 1);
    for (int i = 0; i < 8; i++) drive(d[i], C);
`ifdef UART_RX_PARITY_EN
    drive(par_b, C);
`endif
    drive(stop_b, C);
    drive(1'b0, low_after);
    drive(1'b1, gap);
  endtask

  // Reference: what a receiver must report for one frame, and when.
  task automatic expect_frame(input int t0, input logic [7:0] d, input logic par_b, input logic stop_b);
    ev_t e;
    e.t = t0 + 1 + LAT;
    if (!stop_b) begin
      e.kind = K_FERR;
      e.b    = last_good;
`ifdef UART_RX_PARITY_EN
    end else if ((^d) != par_b) begin
      e.kind = K_PERR;
      e.b    = last_good;
`endif
    end else begin
      e.kind    = K_DV;
      e.b       = d;
      last_good = d;
    end
    exp_q.push_back(e);
  endtask

  task automatic compare(input string tag);
    check({tag, " event count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) begin
        check({tag, " time"}, obs_q[i].t, exp_q[i].t);
        check({tag, " kind"}, obs_q[i].kind, exp_q[i].kind);
        check({tag, " byte"}, obs_q[i].b, exp_q[i].b);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[5];
    int   t0;
    int   act_before;
    logic [7:0] d;
    logic stop_b, par_b;

    vecs[0] = '{data: 8'hA5, stop_b: 1'b1, low_after: 0,  gap: 10, exp_kind: K_DV,   exp_byte: 8'hA5};
    vecs[1] = '{data: 8'h00, stop_b: 1'b1, low_after: 0,  gap: 0,  exp_kind: K_DV,   exp_byte: 8'h00};
    vecs[2] = '{data: 8'hFF, stop_b: 1'b1, low_after: 0,  gap: 10, exp_kind: K_DV,   exp_byte: 8'hFF};
    vecs[3] = '{data: 8'h3C, stop_b: 1'b0, low_after: 50, gap: 10, exp_kind: K_FERR, exp_byte: 8'hFF};
    vecs[4] = '{data: 8'h81, stop_b: 1'b1, low_after: 0,  gap: 10, exp_kind: K_DV,   exp_byte: 8'h81};

    i_rst       = 1'b1;
    i_rx_serial = 1'b1;
    last_good   = 8'h00;
    repeat (3) @(negedge clk);
    check("reset rx_dv", o_rx_dv, 0);
    check("reset rx_byte", o_rx_byte, 8'h00);
    check("reset rx_act", o_rx_act, 0);
    check("reset frame_err", o_frame_err, 0);
    i_rst = 1'b0;
    drive(1'b1, 5);
    obs_q.delete();

    // Directed table: single frame, back-to-back pair, framing error with long break, recovery.
    for (int i = 0; i < 5; i++) begin
      ev_t e;
      send_frame(vecs[i].data, ^vecs[i].data, vecs[i].stop_b, vecs[i].low_after, vecs[i].gap, t0);
      e.t    = t0 + 1 + LAT;
      e.kind = vecs[i].exp_kind;
      e.b    = vecs[i].exp_byte;
      exp_q.push_back(e);
    end
    last_good = 8'h81;
    drive(1'b1, 20);
    if (obs_q.size() >= 3) check("back-to-back spacing", obs_q[2].t - obs_q[1].t, 10 * C);
    compare("table");

    // One-clock low glitch on an idle line.
    act_before = act_cnt;
    @(negedge clk);
    i_rx_serial = 1'b0;
    @(negedge clk);
    i_rx_serial = 1'b1;
    drive(1'b1, 12);
    check("glitch act cycles", act_cnt - act_before, 2);
    check("glitch act idle", o_rx_act, 0);
    compare("glitch");

    // Reset in the middle of data bit 4 of 8'h5A, then a clean frame.
    d = 8'h5A;
    @(negedge clk);
    i_rx_serial = 1'b0;
    drive(1'b0, C - 1);
    for (int i = 0; i < 4; i++) drive(d[i], C);
    drive(d[4], C / 2);
    @(negedge clk);
    i_rst       = 1'b1;
    i_rx_serial = 1'b1;
    @(negedge clk);
    check("midreset rx_dv", o_rx_dv, 0);
    check("midreset rx_byte", o_rx_byte, 8'h00);
    check("midreset rx_act", o_rx_act, 0);
    check("midreset frame_err", o_frame_err, 0);
    i_rst     = 1'b0;
    last_good = 8'h00;
    drive(1'b1, 10);
    send_frame(8'hC3, ^8'hC3, 1'b1, 0, 10, t0);
    expect_frame(t0, 8'hC3, ^8'hC3, 1'b1);
    drive(1'b1, 10);
    compare("midreset");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 0, 10, t0);
    expect_frame(t0, 8'h07, 1'b1, 1'b1);
    send_frame(8'h07, 1'b0, 1'b1, 0, 10, t0);
    expect_frame(t0, 8'h07, 1'b0, 1'b1);
    drive(1'b1, 20);
    compare("parity");
`endif

    // Randomized frames: random data, stop-bit errors, break lengths and idle gaps.
    for (int n = 0; n < 40; n++) begin
      int low_after, gap;
      d         = 8'($urandom_range(0, 255));
      stop_b    = ($urandom_range(0, 3) != 0);
      par_b     = ($urandom_range(0, 3) != 0) ? ^d : ~(^d);
      low_after = stop_b ? 0 : int'($urandom_range(0, 20));
      gap       = stop_b ? int'($urandom_range(0, 6)) : int'($urandom_range(2, 8));
      send_frame(d, par_b, stop_b, low_after, gap, t0);
      expect_frame(t0, d, par_b, stop_b);
    end
    drive(1'b1, 60);
    compare("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
